// File: rtl/audio_pkg.sv
// Shared audio definitions: volume ramp states, the default gain index width,
// and a helper for sizing modulo counters.
package audio_pkg;

  localparam int DEFAULT_VOLUME_BITS = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } vol_state_t;

  // A modulo-1 counter still needs one bit to hold its single value.
  function automatic int div_width(input int step_div);
    return (step_div > 1) ? $clog2(step_div) : 1;
  endfunction

endpackage

// File: rtl/step_divider.sv
// Counts sample ticks modulo STEP_DIV; step pulses on the tick that wraps the count.
module step_divider
  import audio_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic step
);

  localparam int CNT_W = div_width(STEP_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             at_last;

  assign at_last = (div_cnt == LAST);
  assign step    = tick && !clear && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= at_last ? '0 : div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/volume_ramp.sv
// Slews the per-channel gain index toward the requested (or muted) target one
// LSB per STEP_DIV sample ticks, so gain changes land only on sample boundaries.
module volume_ramp
  import audio_pkg::*;
#(
  parameter int VOLUME_BITS = DEFAULT_VOLUME_BITS,
  parameter int STEP_DIV    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_tick,
  input  logic                   tgt_valid,
  output logic                   tgt_ready,
  input  logic [VOLUME_BITS-1:0] tgt_volume,
  input  logic                   mute,
  output logic [VOLUME_BITS-1:0] volume,
  output logic                   ramping,
  output logic                   done
);

  vol_state_t             state, state_next;
  logic [VOLUME_BITS-1:0] target_q, target_next;
  logic [VOLUME_BITS-1:0] volume_next;
  logic [VOLUME_BITS-1:0] eff_tgt;
  logic                   done_next;
  logic                   div_clear;
  logic                   div_tick;
  logic                   step;

  assign eff_tgt   = mute ? '0 : target_q;
  assign tgt_ready = (state == IDLE);
  assign ramping   = (state == RAMP);

  // Divider is held clear in IDLE so every ramp starts from a zero count.
  step_divider #(
    .STEP_DIV(STEP_DIV)
  ) u_step_divider (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(div_clear),
    .tick (div_tick),
    .step (step)
  );

  always_comb begin
    state_next  = state;
    target_next = target_q;
    volume_next = volume;
    done_next   = 1'b0;
    div_clear   = 1'b0;
    div_tick    = 1'b0;
    case (state)
      IDLE: begin
        div_clear = 1'b1;
        if (tgt_valid) begin
          target_next = tgt_volume;
          state_next  = RAMP;
        end else if (eff_tgt != volume) begin
          state_next = RAMP;
        end
      end
      RAMP: begin
        // Arrival check wins over any step in the same cycle.
        if (volume == eff_tgt) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          div_tick = sample_tick;
          if (step) begin
            volume_next = (eff_tgt > volume) ? volume + VOLUME_BITS'(1)
                                             : volume - VOLUME_BITS'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target_q <= '0;
      volume   <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      target_q <= target_next;
      volume   <= volume_next;
      done     <= done_next;
    end
  end

endmodule
